lfsr_checker: RTL and testbench
===============================

LFSR_CHECKER -- requirements
Module: lfsr_checker

Interface
REQ-001 Parameter LOCK_CNT, default 4: consecutive matching words required to declare lock (range 1..15).
REQ-002 Parameter LOSS_CNT, default 3: consecutive mismatching words while locked that force resync (range 1..15).
REQ-003 clock  input  1  single clock, all state updates on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  in_data carries one generator word this cycle.
REQ-006 in_data  input  16  received generator word (counter value or 16-bit LFSR state).
REQ-007 mode  input  1  0 = up-counter stream, 1 = LFSR stream.
REQ-008 clear_err  input  1  synchronous clear of err_count.
REQ-009 locked  output  1  checker is in LOCKED state.
REQ-010 err_pulse  output  1  one-cycle pulse per mismatching word while locked.
REQ-011 err_count  output  16  saturating count of mismatches seen while locked.
REQ-012 word_count  output  16  count of valid words received, wraps mod 2^16.
REQ-013 expected  output  16  predicted value of the next word.
REQ-014 stuck  output  1  LFSR mode with all-zero state held (lock-up detected).

Function
REQ-015 Prediction rule, counter mode: expected = previous word + 1, mod 2^16 (0xFFFF -> 0x0000).
REQ-016 Prediction rule, LFSR mode: expected = {prev[14:0], prev[15]^prev[13]^prev[12]^prev[10]}.
REQ-017 The states SHALL be IDLE, SEED, LOCKED, each entered only as listed below.
REQ-018 IDLE: on in_valid, store in_data as the seed, go to SEED, match_run = 0.
REQ-019 SEED: on in_valid with in_data == expected, match_run increments; on reaching LOCK_CNT, go to LOCKED.
REQ-020 SEED: on in_valid with mismatch, in_data becomes the new seed, match_run = 0, stay in SEED, no err_pulse.
REQ-021 LOCKED: on in_valid with match, miss_run = 0.
REQ-022 LOCKED: on in_valid with mismatch, err_pulse = 1 the next cycle, err_count += 1 (saturate 0xFFFF), miss_run increments.
REQ-023 LOCKED: when miss_run reaches LOSS_CNT, go to SEED, seed = in_data, match_run = 0, locked drops the next cycle.
REQ-024 On every accepted word, in every state (including a mismatch), the prediction base SHALL become in_data, so expected tracks the stream.
REQ-025 Latency: locked, err_pulse, err_count, word_count and expected are registered and reflect a word 1 cycle after its in_valid edge.
REQ-026 in_valid low: no state, counter or prediction change; err_pulse = 0.
REQ-027 A mode change, sampled as mode differing from its registered copy, SHALL force SEED with the current word (if valid) as seed, match_run = 0, and no err_pulse; mode change has priority over compare.
REQ-028 clear_err has priority over a coincident increment: err_count = 0, but err_pulse still asserts for that mismatch.
REQ-029 stuck = 1 while mode = 1 and the prediction base == 0x0000; the zero word predicts zero and may lock.
REQ-030 word_count increments on every in_valid, wrapping 0xFFFF -> 0x0000.

Reset
REQ-031 reset_n low SHALL asynchronously force IDLE, locked = 0, err_pulse = 0, err_count = 0, word_count = 0, expected = 0, stuck = 0, and run counters = 0.
REQ-032 reset_n deassertion mid-stream restarts acquisition from IDLE; the first post-reset word is a seed and never an error.

Verification
REQ-033 Scenario: counter mode, LOCK_CNT = 4, words 0x0010..0x0014 -> locked = 1 one cycle after 0x0014, err_count = 0, word_count = 5.
REQ-034 Scenario: LFSR mode, seed 0xACE1 -> expected = 0x59C3; send 0x59C3 -> match_run = 1, no err_pulse.
REQ-035 Scenario: locked counter stream, one corrupted word (0x0100 instead of 0x0020), then 0x0101 -> single err_pulse, err_count = 1, locked stays 1, expected = 0x0102.
REQ-036 Scenario: locked, 3 consecutive mismatches with LOSS_CNT = 3 -> err_count = 3, locked = 0, state SEED seeded with the 3rd word.
REQ-037 Scenario: counter wrap 0xFFFE, 0xFFFF, 0x0000 while locked -> no errors; clear_err coincident with a mismatch -> err_count = 0 and err_pulse = 1.
REQ-038 Scenario: mode toggled 0 -> 1 while locked -> locked = 0 next cycle, no err_pulse; reset_n pulsed mid-stream -> all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/lfsr_checker.sv
// lfsr_checker: acquires and tracks a received generator stream (16-bit up-counter
// or 16-bit Fibonacci LFSR), declares lock after a run of correct predictions,
// counts mismatches while locked and falls back to resynchronisation after a run
// of consecutive misses.
module lfsr_checker #(
    parameter int unsigned LOCK_CNT = 4,
    parameter int unsigned LOSS_CNT = 3
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        in_valid,
    input  logic [15:0] in_data,
    input  logic        mode,
    input  logic        clear_err,
    output logic        locked,
    output logic        err_pulse,
    output logic [15:0] err_count,
    output logic [15:0] word_count,
    output logic [15:0] expected,
    output logic        stuck
);

    localparam logic [3:0] LOCK_N = 4'(LOCK_CNT);
    localparam logic [3:0] LOSS_N = 4'(LOSS_CNT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEED   = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t      state_q;
    logic        mode_q;
    logic [15:0] base_q;
    logic [15:0] expected_q;
    logic [15:0] err_count_q;
    logic [15:0] word_count_q;
    logic [3:0]  match_run_q;
    logic [3:0]  miss_run_q;
    logic        err_pulse_q;
    logic        stuck_q;

    logic        mode_chg_d;
    logic        hit_d;
    logic [15:0] pred_d;
    logic [3:0]  match_inc_d;
    logic [3:0]  miss_inc_d;

    // One step of the 16-bit Fibonacci LFSR (taps 16,14,13,11).
    function automatic logic [15:0] lfsr_step(input logic [15:0] prev);
        return {prev[14:0], prev[15] ^ prev[13] ^ prev[12] ^ prev[10]};
    endfunction

    // Next word the generator should emit after prev, for the given stream type.
    function automatic logic [15:0] predict(input logic [15:0] prev, input logic lfsr_mode);
        return lfsr_mode ? lfsr_step(prev) : prev + 16'd1;
    endfunction

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Compare and prediction helpers for the current input word.
    always_comb begin
        mode_chg_d  = (mode != mode_q);
        hit_d       = (in_data == expected_q);
        pred_d      = predict(in_data, mode);
        match_inc_d = match_run_q + 4'd1;
        miss_inc_d  = miss_run_q + 4'd1;
    end

    // Acquisition FSM with its run counters, error/word counters and prediction.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            mode_q       <= 1'b0;
            base_q       <= 16'd0;
            expected_q   <= 16'd0;
            err_count_q  <= 16'd0;
            word_count_q <= 16'd0;
            match_run_q  <= 4'd0;
            miss_run_q   <= 4'd0;
            err_pulse_q  <= 1'b0;
            stuck_q      <= 1'b0;
        end else begin
            mode_q      <= mode;
            err_pulse_q <= 1'b0;
            if (clear_err) begin
                err_count_q <= 16'd0;
            end

            if (in_valid) begin
                // Every accepted word becomes the new prediction base, hit or miss.
                word_count_q <= word_count_q + 16'd1;
                base_q       <= in_data;
                expected_q   <= pred_d;
                stuck_q      <= mode && (in_data == 16'd0);

                if (state_q == IDLE || mode_chg_d) begin
                    // Fresh seed: first word after reset, or the stream type changed.
                    state_q     <= SEED;
                    match_run_q <= 4'd0;
                    miss_run_q  <= 4'd0;
                end else begin
                    case (state_q)
                        SEED: begin
                            if (hit_d) begin
                                if (match_inc_d == LOCK_N) begin
                                    state_q     <= LOCKED;
                                    match_run_q <= 4'd0;
                                    miss_run_q  <= 4'd0;
                                end else begin
                                    match_run_q <= match_inc_d;
                                end
                            end else begin
                                // Mismatch while acquiring just restarts from this word.
                                match_run_q <= 4'd0;
                            end
                        end
                        LOCKED: begin
                            if (hit_d) begin
                                miss_run_q <= 4'd0;
                            end else begin
                                err_pulse_q <= 1'b1;
                                if (!clear_err) begin
                                    err_count_q <= sat_inc(err_count_q);
                                end
                                if (miss_inc_d == LOSS_N) begin
                                    state_q     <= SEED;
                                    match_run_q <= 4'd0;
                                    miss_run_q  <= 4'd0;
                                end else begin
                                    miss_run_q <= miss_inc_d;
                                end
                            end
                        end
                        default: begin
                            state_q     <= IDLE;
                            match_run_q <= 4'd0;
                            miss_run_q  <= 4'd0;
                        end
                    endcase
                end
            end else if (mode_chg_d && state_q != IDLE) begin
                // Stream type changed between words: drop lock and re-predict from
                // the last word under the new rule so the next word can still match.
                state_q     <= SEED;
                match_run_q <= 4'd0;
                miss_run_q  <= 4'd0;
                expected_q  <= predict(base_q, mode);
                stuck_q     <= mode && (base_q == 16'd0);
            end
        end
    end

    assign locked     = (state_q == LOCKED);
    assign err_pulse  = err_pulse_q;
    assign err_count  = err_count_q;
    assign word_count = word_count_q;
    assign expected   = expected_q;
    assign stuck      = stuck_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// tb_lfsr_checker: directed scenarios plus a randomized generator stream, all
// outputs compared every cycle against a rule-level reference model.
module tb_lfsr_checker;

    localparam int LOCK = 4;
    localparam int LOSS = 3;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic [15:0] in_data;
    logic        mode;
    logic        clear_err;
    logic        locked;
    logic        err_pulse;
    logic [15:0] err_count;
    logic [15:0] word_count;
    logic [15:0] expected;
    logic        stuck;

    int total = 0;
    int bad   = 0;

    lfsr_checker #(.LOCK_CNT(LOCK), .LOSS_CNT(LOSS)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .mode       (mode),
        .clear_err  (clear_err),
        .locked     (locked),
        .err_pulse  (err_pulse),
        .err_count  (err_count),
        .word_count (word_count),
        .expected   (expected),
        .stuck      (stuck)
    );

    always #5 clock = ~clock;

    // Reference model state (phase: 0 = no seed yet, 1 = acquiring, 2 = locked).
    int m_phase, m_run, m_miss, m_err, m_words, m_exp, m_base;
    bit m_mode, m_pulse, m_stuck;

    function automatic int ref_pred(input int p, input bit lfsr);
        int fb;
        if (!lfsr) return (p + 1) % 65536;
        fb = ((p >> 15) ^ (p >> 13) ^ (p >> 12) ^ (p >> 10)) & 1;
        return ((p * 2) % 65536) | fb;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_run = 0; m_miss = 0; m_err = 0; m_words = 0;
        m_exp = 0; m_base = 0; m_mode = 0; m_pulse = 0; m_stuck = 0;
    endtask

    task automatic model_step(input bit v, input int d, input bit md, input bit clr);
        bit chg;
        chg = (md != m_mode);
        m_mode = md;
        m_pulse = 0;
        if (clr) m_err = 0;
        if (v) begin
            m_words = (m_words + 1) % 65536;
            if (m_phase == 0 || chg) begin
                m_phase = 1; m_run = 0; m_miss = 0;
            end else if (m_phase == 1) begin
                if (d == m_exp) begin
                    m_run++;
                    if (m_run == LOCK) begin m_phase = 2; m_run = 0; m_miss = 0; end
                end else m_run = 0;
            end else begin
                if (d == m_exp) m_miss = 0;
                else begin
                    m_pulse = 1;
                    if (!clr && m_err < 65535) m_err++;
                    m_miss++;
                    if (m_miss == LOSS) begin m_phase = 1; m_run = 0; m_miss = 0; end
                end
            end
            m_base = d;
            m_exp = ref_pred(d, md);
            m_stuck = md && (d == 0);
        end else if (chg && m_phase != 0) begin
            m_phase = 1; m_run = 0; m_miss = 0;
            m_exp = ref_pred(m_base, md);
            m_stuck = md && (m_base == 0);
        end
    endtask

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] want);
        total++;
        if (obs !== want) begin
            bad++;
            $display("FAIL %s @%0t got=%0h want=%0h", tag, $time, obs, want);
        end
    endtask

    task automatic check_model();
        chk_eq("locked", {31'd0, locked}, (m_phase == 2) ? 1 : 0);
        chk_eq("err_pulse", {31'd0, err_pulse}, {31'd0, m_pulse});
        chk_eq("err_count", {16'd0, err_count}, m_err);
        chk_eq("word_count", {16'd0, word_count}, m_words);
        chk_eq("expected", {16'd0, expected}, m_exp);
        chk_eq("stuck", {31'd0, stuck}, {31'd0, m_stuck});
    endtask

    // Apply one cycle of inputs (called just after a falling edge).
    task automatic drive(input bit v, input int d, input bit md, input bit clr);
        in_valid = v; in_data = d[15:0]; mode = md; clear_err = clr;
        @(posedge clock);
        model_step(v, d, md, clr);
        #1;
        check_model();
        @(negedge clock);
    endtask

    task automatic check_all_zero(input string tag);
        chk_eq({tag, "_locked"}, {31'd0, locked}, 0);
        chk_eq({tag, "_pulse"}, {31'd0, err_pulse}, 0);
        chk_eq({tag, "_errcnt"}, {16'd0, err_count}, 0);
        chk_eq({tag, "_wcnt"}, {16'd0, word_count}, 0);
        chk_eq({tag, "_exp"}, {16'd0, expected}, 0);
        chk_eq({tag, "_stuck"}, {31'd0, stuck}, 0);
    endtask

    initial begin
        int gen;
        bit gm;
        reset_n = 1'b0; in_valid = 1'b0; in_data = 16'd0; mode = 1'b0; clear_err = 1'b0;
        model_reset();
        #12;
        check_all_zero("reset");
        @(negedge clock);
        reset_n = 1'b1;

        // Counter acquisition: seed plus four matches locks.
        for (int w = 'h10; w <= 'h14; w++) drive(1, w, 0, 0);
        chk_eq("s1_locked", {31'd0, locked}, 1);
        chk_eq("s1_wcnt", {16'd0, word_count}, 5);
        chk_eq("s1_errcnt", {16'd0, err_count}, 0);

        // Locked stream with one corrupted word.
        for (int w = 'h15; w <= 'h1F; w++) drive(1, w, 0, 0);
        drive(1, 'h0100, 0, 0);
        chk_eq("s3_pulse", {31'd0, err_pulse}, 1);
        drive(1, 'h0101, 0, 0);
        chk_eq("s3_pulse_gone", {31'd0, err_pulse}, 0);
        chk_eq("s3_errcnt", {16'd0, err_count}, 1);
        chk_eq("s3_locked", {31'd0, locked}, 1);
        chk_eq("s3_exp", {16'd0, expected}, 'h0102);

        // Three consecutive misses lose lock and reseed from the third.
        drive(0, 0, 0, 1);
        drive(1, 'h0500, 0, 0);
        drive(1, 'h0600, 0, 0);
        drive(1, 'h0700, 0, 0);
        chk_eq("s4_errcnt", {16'd0, err_count}, 3);
        chk_eq("s4_locked", {31'd0, locked}, 0);
        chk_eq("s4_exp", {16'd0, expected}, 'h0701);

        // Counter wrap while locked, then clear_err coincident with a miss.
        for (int w = 'hFFFA; w <= 'hFFFF; w++) drive(1, w, 0, 0);
        drive(1, 'h0000, 0, 0);
        drive(1, 'h0001, 0, 0);
        chk_eq("s5_locked", {31'd0, locked}, 1);
        chk_eq("s5_errcnt", {16'd0, err_count}, 3);
        drive(1, 'h1234, 0, 1);
        chk_eq("s5_clr_pulse", {31'd0, err_pulse}, 1);
        chk_eq("s5_clr_cnt", {16'd0, err_count}, 0);

        // Mode change while locked, then LFSR seed and prediction.
        drive(1, 'h1235, 0, 0);
        drive(1, 'hACE1, 1, 0);
        chk_eq("s6_locked", {31'd0, locked}, 0);
        chk_eq("s6_pulse", {31'd0, err_pulse}, 0);
        chk_eq("s2_exp", {16'd0, expected}, 'h59C3);
        drive(1, 'h59C3, 1, 0);
        chk_eq("s2_pulse", {31'd0, err_pulse}, 0);

        // All-zero LFSR state: stuck flag, zero predicts zero and can lock.
        for (int i = 0; i < 5; i++) drive(1, 0, 1, 0);
        chk_eq("stuck_flag", {31'd0, stuck}, 1);
        chk_eq("stuck_lock", {31'd0, locked}, 1);

        // Asynchronous reset mid-stream, observed before any clock edge.
        in_valid = 1'b1; in_data = 16'h0000;
        #2;
        reset_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        model_reset();
        @(negedge clock);
        reset_n = 1'b1;
        drive(1, 'h7777, 1, 0);
        chk_eq("post_rst_pulse", {31'd0, err_pulse}, 0);

        // Randomized stream with corruptions, gaps, clears and mode flips.
        gen = 'h7777;
        gm = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            bit v, clr;
            int d;
            v = ($urandom % 8) != 0;
            clr = ($urandom % 25) == 0;
            if (($urandom % 80) == 0) gm = ~gm;
            d = ref_pred(gen, gm);
            if (($urandom % 12) == 0) d = (($urandom % 6) == 0) ? 0 : int'($urandom % 65536);
            if (v) gen = d;
            drive(v, d, gm, clr);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
